// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the ALU sequencer: default datapath width and ALU opcodes.
// Latency: n/a (definitions only).
// Backpressure: n/a.
// The opcodes match the core's combinational ALU decode.
package alu_sequencer_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/alu_sequencer.sv
// Multi-cycle MUL / DIVU sequencer that borrows the core's combinational ALU.
// Latency: MUL done XLEN+1 cycles after accept; DIVU XLEN+1..2*XLEN+1; divide-by-zero 1.
// Backpressure: ready is high only in IDLE; start is ignored while busy.
//
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   start, op, op_a, op_b      request (op 0=MUL low half, 1=DIVU), sampled when ready=1
//   flush                      synchronous abort of an in-flight operation
//   ready, done, illegal       status; done/illegal are one-cycle pulses
//   res_lo, res_hi             product/0 or quotient/remainder, held between operations
//   alu_A, alu_B, alu_control  operands and opcode driven to the external ALU
//   alu_result, alu_zero       external ALU response
// Build option: define ALU_SEQ_DIV_EN to include the divider; otherwise DIVU
// completes immediately with illegal set.
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            op,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            ready,
  output logic            done,
  output logic [XLEN-1:0] res_lo,
  output logic [XLEN-1:0] res_hi,
  output logic            illegal,
  output logic [XLEN-1:0] alu_A,
  output logic [XLEN-1:0] alu_B,
  output logic [2:0]      alu_control,
  input  logic [XLEN-1:0] alu_result,
  input  logic            alu_zero
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] MUL_STEP = 3'd1;
  localparam logic [2:0] DIV_CMP  = 3'd2;
  localparam logic [2:0] DIV_SUB  = 3'd3;
  localparam logic [2:0] DONE     = 3'd4;

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

  logic [2:0]      state_q, state_d;
  // a: multiplicand (MUL) or dividend shifting out / quotient shifting in (DIVU)
  logic [XLEN-1:0] a_q, a_d;
  // b: multiplier (MUL) or divisor (DIVU)
  logic [XLEN-1:0] b_q, b_d;
  // acc: product accumulator (MUL) or partial remainder (DIVU)
  logic [XLEN-1:0] acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] res_lo_q, res_lo_d;
  logic [XLEN-1:0] res_hi_q, res_hi_d;
  logic            ill_q, ill_d;
  logic            last_step;

`ifdef ALU_SEQ_DIV_EN
  logic [XLEN-1:0] rem_shift;
`else
  logic            unused_alu_zero;
  assign unused_alu_zero = alu_zero;
`endif

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    res_lo_d    = res_lo_q;
    res_hi_d    = res_hi_q;
    ill_d       = ill_q;
    alu_control = ALU_AND;
    alu_A       = '0;
    alu_B       = '0;
    last_step   = (cnt_q == CNT_LAST);
`ifdef ALU_SEQ_DIV_EN
    rem_shift   = {acc_q[XLEN-2:0], a_q[XLEN-1]};
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d   = op_a;
          b_d   = op_b;
          acc_d = '0;
          cnt_d = '0;
          ill_d = 1'b0;
          if (!op) begin
            state_d = MUL_STEP;
          end else begin
`ifdef ALU_SEQ_DIV_EN
            if (op_b == '0) begin
              state_d  = DONE;
              res_lo_d = '1;
              res_hi_d = op_a;
            end else begin
              state_d = DIV_CMP;
            end
`else
            state_d  = DONE;
            res_lo_d = '1;
            res_hi_d = '0;
            ill_d    = 1'b1;
`endif
          end
        end
      end

      MUL_STEP: begin
        if (b_q[0]) begin
          alu_control = ALU_ADD;
          alu_A       = acc_q;
          alu_B       = a_q;
          acc_d       = alu_result;
        end
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + CW'(1);
        if (last_step) begin
          state_d  = DONE;
          res_lo_d = acc_d;
          res_hi_d = '0;
        end
      end

`ifdef ALU_SEQ_DIV_EN
      DIV_CMP: begin
        alu_control = ALU_SLT;
        alu_A       = rem_shift;
        alu_B       = b_q;
        acc_d       = rem_shift;
        a_d         = {a_q[XLEN-2:0], 1'b0};
        // A set remainder MSB means the shifted value exceeds XLEN bits and
        // is certainly >= divisor; the SLT result would be meaningless.
        if (acc_q[XLEN-1] || alu_zero) begin
          state_d = DIV_SUB;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (last_step) begin
            state_d  = DONE;
            res_lo_d = a_d;
            res_hi_d = acc_d;
          end
        end
      end

      DIV_SUB: begin
        // Wrap-around subtraction restores the lost overflow bit implicitly.
        alu_control = ALU_SUB;
        alu_A       = acc_q;
        alu_B       = b_q;
        acc_d       = alu_result;
        a_d         = {a_q[XLEN-1:1], 1'b1};
        cnt_d       = cnt_q + CW'(1);
        if (last_step) begin
          state_d  = DONE;
          res_lo_d = a_d;
          res_hi_d = acc_d;
        end else begin
          state_d = DIV_CMP;
        end
      end
`else
      DIV_CMP, DIV_SUB: state_d = IDLE;
`endif

      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Abort wins over any completion in the same cycle and leaves old results.
    if (flush && (state_q != IDLE)) begin
      state_d  = IDLE;
      res_lo_d = res_lo_q;
      res_hi_d = res_hi_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      res_lo_q <= '0;
      res_hi_q <= '0;
      ill_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      res_lo_q <= res_lo_d;
      res_hi_q <= res_hi_d;
      ill_q    <= ill_d;
    end
  end

  assign ready   = (state_q == IDLE);
  assign done    = (state_q == DONE);
  assign illegal = done & ill_q;
  assign res_lo  = res_lo_q;
  assign res_hi  = res_hi_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer with XLEN=32 and a behavioural copy of the core ALU.
// Stimulus pushes expected results into a queue; a negedge monitor pops on done.
// Expectations follow the ALU_SEQ_DIV_EN build option.
module tb_alu_sequencer;
  import alu_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        op;
  logic [31:0] op_a, op_b;
  logic        flush;
  logic        ready, done, illegal;
  logic [31:0] res_lo, res_hi;
  logic [31:0] alu_A, alu_B, alu_result;
  logic [2:0]  alu_control;
  logic        alu_zero;

  typedef struct {
    string       name;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        ill;
    int          acc_cyc;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_sequencer #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .op_a(op_a), .op_b(op_b),
    .flush(flush), .ready(ready), .done(done), .res_lo(res_lo), .res_hi(res_hi),
    .illegal(illegal), .alu_A(alu_A), .alu_B(alu_B), .alu_control(alu_control),
    .alu_result(alu_result), .alu_zero(alu_zero)
  );

  // Core ALU model; SLT compares as unsigned so full-range divisors work.
  always_comb begin
    alu_result = 32'h0;
    case (alu_control)
      ALU_ADD: alu_result = alu_A + alu_B;
      ALU_SUB: alu_result = alu_A - alu_B;
      ALU_AND: alu_result = alu_A & alu_B;
      ALU_OR:  alu_result = alu_A | alu_B;
      ALU_SLT: alu_result = {31'h0, (alu_A < alu_B)};
      default: alu_result = 32'h0;
    endcase
    alu_zero = (alu_result == 32'h0);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Issue one request; when push is set the expected response is queued.
  task automatic issue(input string nm, input logic o, input logic [31:0] a,
                       input logic [31:0] b, input bit push, input logic [31:0] lo,
                       input logic [31:0] hi, input logic il, input int lat);
    exp_t e;
    int n = 0;
    @(negedge clk);
    while (!ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_ready"}, {31'h0, ready}, 32'h1);
    start = 1'b1;
    op    = o;
    op_a  = a;
    op_b  = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (push) begin
      e.name    = nm;
      e.lo      = lo;
      e.hi      = hi;
      e.ill     = il;
      e.acc_cyc = cyc;
      e.lat     = lat;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_drain(input string nm);
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_drained"}, 32'(exp_q.size()), 32'h0);
  endtask

  // Monitor: compare whenever the DUT reports completion.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: res_lo %h res_hi %h illegal %b", res_lo, res_hi, illegal);
      end else begin
        mon_e = exp_q.pop_front();
        chk({mon_e.name, "_res_lo"}, res_lo, mon_e.lo);
        chk({mon_e.name, "_res_hi"}, res_hi, mon_e.hi);
        chk({mon_e.name, "_illegal"}, {31'h0, illegal}, {31'h0, mon_e.ill});
        chk({mon_e.name, "_latency"}, 32'(cyc + 1 - mon_e.acc_cyc), 32'(mon_e.lat));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; op = 1'b0; op_a = 32'h0; op_b = 32'h0; flush = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'h0, ready}, 32'h1);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_illegal", {31'h0, illegal}, 32'h0);
    chk("rst_res_lo", res_lo, 32'h0);
    chk("rst_res_hi", res_hi, 32'h0);
    chk("rst_alu_ctrl", {29'h0, alu_control}, {29'h0, ALU_AND});
    chk("rst_alu_A", alu_A, 32'h0);
    chk("rst_alu_B", alu_B, 32'h0);
    rst = 1'b0;

    // Multiply: latency is always XLEN+1.
    issue("mul7x6",     0, 32'd7,        32'd6,        1, 32'd42,       32'h0, 0, 33);
    issue("mulFFx2",    0, 32'hFFFFFFFF, 32'd2,        1, 32'hFFFFFFFE, 32'h0, 0, 33);
    issue("mulshift",   0, 32'h12345678, 32'h10,       1, 32'h23456780, 32'h0, 0, 33);
    issue("mul0x5",     0, 32'd0,        32'd5,        1, 32'd0,        32'h0, 0, 33);
    issue("mulFFxFF",   0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'h1,        32'h0, 0, 33);
    wait_drain("mul");

`ifdef ALU_SEQ_DIV_EN
    // Divide: XLEN compare cycles plus one subtract cycle per quotient one-bit.
    issue("divu100_7",  1, 32'd100,      32'd7,        1, 32'd14,       32'd2,        0, 36);
    issue("divuFF_80",  1, 32'hFFFFFFFF, 32'h80000000, 1, 32'h1,        32'h7FFFFFFF, 0, 34);
    issue("divuDEAD",   1, 32'hDEADBEEF, 32'h10,       1, 32'h0DEADBEE, 32'hF,        0, 53);
    issue("divu3_10",   1, 32'd3,        32'd10,       1, 32'd0,        32'd3,        0, 33);
    issue("divu5_0",    1, 32'd5,        32'd0,        1, 32'hFFFFFFFF, 32'd5,        0, 1);
`else
    // Divider not built: every DIVU is rejected one cycle after acceptance.
    issue("divu100_7",  1, 32'd100,      32'd7,        1, 32'hFFFFFFFF, 32'h0, 1, 1);
    issue("divuFF_80",  1, 32'hFFFFFFFF, 32'h80000000, 1, 32'hFFFFFFFF, 32'h0, 1, 1);
    issue("divu5_0",    1, 32'd5,        32'd0,        1, 32'hFFFFFFFF, 32'h0, 1, 1);
`endif
    wait_drain("divu");

    // Start held while busy must not be taken.
    issue("mul3x5busy", 0, 32'd3, 32'd5, 1, 32'd15, 32'h0, 0, 33);
    start = 1'b1; op = 1'b1; op_a = 32'd5; op_b = 32'd0;
    repeat (6) @(negedge clk);
    start = 1'b0; op = 1'b0;
    wait_drain("busy");

    // Flush sampled on the tenth step edge of a multiply.
    issue("mulflush", 0, 32'd9, 32'd9, 0, 32'h0, 32'h0, 0, 0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush_ready", {31'h0, ready}, 32'h1);
    chk("flush_done", {31'h0, done}, 32'h0);
    chk("flush_res_lo", res_lo, 32'd15);
    chk("flush_res_hi", res_hi, 32'h0);
    repeat (40) @(negedge clk);
    chk("flush_idle", {31'h0, ready}, 32'h1);

    // Asynchronous reset in the middle of an operation.
`ifdef ALU_SEQ_DIV_EN
    issue("divurst", 1, 32'hDEADBEEF, 32'd3, 0, 32'h0, 32'h0, 0, 0);
`else
    issue("mulrst", 0, 32'h1234, 32'h5678, 0, 32'h0, 32'h0, 0, 0);
`endif
    repeat (5) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_ready", {31'h0, ready}, 32'h1);
    chk("arst_done", {31'h0, done}, 32'h0);
    chk("arst_illegal", {31'h0, illegal}, 32'h0);
    chk("arst_res_lo", res_lo, 32'h0);
    chk("arst_res_hi", res_hi, 32'h0);
    chk("arst_alu_A", alu_A, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    issue("mul13x11", 0, 32'd13, 32'd11, 1, 32'd143, 32'h0, 0, 33);
    wait_drain("final");
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
